// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helpers for the key_debounce_tick multi-key debouncer.
// Optional long-press/repeat logic is enabled with the KEY_LONG_PRESS_EN macro.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        UP     = 2'd0,
        DEB_DN = 2'd1,
        DOWN   = 2'd2,
        DEB_UP = 2'd3
    } key_fsm_e;

    // One counter width serves the debounce, hold and repeat counts.
    function automatic int cnt_width(input int stable_ticks, input int long_ticks,
                                     input int repeat_ticks);
        int m;
        m = stable_ticks;
        if (long_ticks > m) m = long_ticks;
        if (repeat_ticks > m) m = repeat_ticks;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, tick-qualified debounce FSM, registered events.
// Long-press/repeat pulses exist only when KEY_LONG_PRESS_EN is defined.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int STABLE_TICKS   = 2,
    parameter int LONG_TICKS     = 100,
    parameter int REPEAT_TICKS   = 20
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     sample_tick_i,
    input  logic     key_raw_i,
    output logic     key_state_o,
    output logic     key_press_o,
    output logic     key_release_o,
    output logic     key_long_o,
    output key_fsm_e fsm_state_o
);

    localparam int            CW      = cnt_width(STABLE_TICKS, LONG_TICKS, REPEAT_TICKS);
    localparam logic          REL_LVL = (KEY_ACTIVE_LOW != 0);
    localparam logic [CW-1:0] ST_LAST = CW'(STABLE_TICKS - 1);

    logic [1:0]    sync_q;
    logic          pressed;
    key_fsm_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Synchroniser idles at the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {REL_LVL, REL_LVL};
        else     sync_q <= {sync_q[0], key_raw_i};
    end

    assign pressed = sync_q[1] ^ REL_LVL;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sample_tick_i) begin
            unique case (state_q)
                UP: begin
                    if (pressed) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = DOWN;
                            cnt_d   = '0;
                            press_d = 1'b1;
                        end else begin
                            state_d = DEB_DN;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                DEB_DN: begin
                    if (!pressed) begin
                        state_d = UP;
                        cnt_d   = '0;
                    end else if (cnt_q == ST_LAST) begin
                        state_d = DOWN;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                DOWN: begin
                    if (!pressed) begin
                        if (STABLE_TICKS == 1) begin
                            state_d   = UP;
                            cnt_d     = '0;
                            release_d = 1'b1;
                        end else begin
                            state_d = DEB_UP;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                DEB_UP: begin
                    if (pressed) begin
                        state_d = DOWN;
                        cnt_d   = '0;
                    end else if (cnt_q == ST_LAST) begin
                        state_d   = UP;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = UP;
                    cnt_d   = '0;
                end
            endcase
        end
        level_d = (state_d == DOWN) || (state_d == DEB_UP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_V = CW'(LONG_TICKS);
    localparam logic [CW-1:0] REP_V  = CW'(REPEAT_TICKS);

    logic [CW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
    logic          long_q, long_d;

    // hold counts ticks spent in DOWN; after the first pulse it restarts as the repeat interval.
    always_comb begin
        hold_d = hold_q;
        rep_d  = rep_q;
        long_d = 1'b0;
        if (sample_tick_i) begin
            if (state_q != DOWN && state_d == DOWN) begin
                hold_d = '0;
                rep_d  = 1'b0;
            end else if (state_q == DOWN && state_d == DOWN) begin
                hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
                if (!rep_q) begin
                    if (hold_d == LONG_V) begin
                        long_d = 1'b1;
                        rep_d  = 1'b1;
                        hold_d = '0;
                    end
                end else if (REPEAT_TICKS > 0 && hold_d == REP_V) begin
                    long_d = 1'b1;
                    hold_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
            long_q <= long_d;
        end
    end

    assign key_long_o = long_q;
`else
    assign key_long_o = 1'b0;
`endif

    assign key_state_o   = level_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;
    assign fsm_state_o   = state_q;

endmodule

// File: rtl/key_debounce_tick.sv
// Multi-key debouncer/edge detector: fans ports out to one key_debounce_ch per key.
// Define KEY_LONG_PRESS_EN to enable key_long long-press/repeat pulses.
module key_debounce_tick
    import key_debounce_pkg::*;
#(
    parameter int KEY_NUM        = 4,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int STABLE_TICKS   = 2,
    parameter int LONG_TICKS     = 100,
    parameter int REPEAT_TICKS   = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_tick,
    input  logic [KEY_NUM-1:0]     key_raw,
    output logic [KEY_NUM-1:0]     key_state,
    output logic [KEY_NUM-1:0]     key_press,
    output logic [KEY_NUM-1:0]     key_release,
    output logic [KEY_NUM-1:0]     key_long,
    output logic [2*KEY_NUM-1:0]   key_fsm_state
);

    for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_ch
        key_fsm_e ch_state;

        key_debounce_ch #(
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW),
            .STABLE_TICKS  (STABLE_TICKS),
            .LONG_TICKS    (LONG_TICKS),
            .REPEAT_TICKS  (REPEAT_TICKS)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .sample_tick_i(sample_tick),
            .key_raw_i    (key_raw[gi]),
            .key_state_o  (key_state[gi]),
            .key_press_o  (key_press[gi]),
            .key_release_o(key_release[gi]),
            .key_long_o   (key_long[gi]),
            .fsm_state_o  (ch_state)
        );

        assign key_fsm_state[2*gi +: 2] = ch_state;
    end

endmodule

// File: tb/tb_key_debounce_tick.sv
// Directed bench for key_debounce_tick (2 keys, active-low, 3-tick debounce, tick every 10 clk).
// Expected pulse events carry their tick index and are checked by an independent monitor.
module tb_key_debounce_tick;

    localparam int W = 16;

    logic       clk;
    logic       rst;
    logic       sample_tick;
    logic [1:0] key_raw;
    logic [1:0] key_state, key_press, key_release, key_long;
    logic [3:0] key_fsm_state;

    logic [W-1:0] exp_q[$];
    int vectors;
    int miscompares;
    int tick_cnt;
    int t;

    key_debounce_tick #(
        .KEY_NUM       (2),
        .KEY_ACTIVE_LOW(1),
        .STABLE_TICKS  (3),
        .LONG_TICKS    (5),
        .REPEAT_TICKS  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .key_raw      (key_raw),
        .key_state    (key_state),
        .key_press    (key_press),
        .key_release  (key_release),
        .key_long     (key_long),
        .key_fsm_state(key_fsm_state)
    );

    // Clock, tick generator and tick counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (9) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    initial tick_cnt = 0;
    always @(posedge clk) if (sample_tick) tick_cnt <= tick_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Driver / checker helpers
    task automatic push_ev(input int tk, input logic [1:0] p, input logic [1:0] r,
                           input logic [1:0] l, input logic [1:0] s);
        logic [7:0] tk8;
        tk8 = tk[7:0];
        exp_q.push_back({tk8, p, r, l, s});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int guard;
        target = tick_cnt + n;
        guard  = 0;
        while (tick_cnt < target && guard < 20 * n + 20) begin
            @(negedge clk);
            guard++;
        end
        if (tick_cnt < target) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_ticks: tick count %0d, required %0d", tick_cnt, target);
        end
    endtask

    // Monitor: every cycle that shows a pulse is one event popped from the scoreboard
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        logic [7:0]   tk8;
        if (!rst && (key_press != 2'b00 || key_release != 2'b00 || key_long != 2'b00)) begin
            tk8 = tick_cnt[7:0];
            act = {tk8, key_press, key_release, key_long, key_state};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: actual=%h (tick,press,rel,long,state) expected none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL event: actual=%h expected=%h (tick,press,rel,long,state)", act, exp);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        key_raw     = 2'b11;
        repeat (5) @(negedge clk);
        chk("reset_outputs", {24'd0, key_state, key_press, key_release, key_long}, 32'd0);
        chk("reset_fsm", {28'd0, key_fsm_state}, 32'd0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle_50clk", {24'd0, key_state, key_press, key_release, key_long}, 32'd0);

        // Clean press on key 0, then release with a one-tick glitch in DEB_UP
        wait_ticks(1);
        t = tick_cnt;
        key_raw[0] = 1'b0;
        push_ev(t + 3, 2'b01, 2'b00, 2'b00, 2'b01);
        wait_ticks(2);
        chk("press_not_early", {30'd0, key_state}, 32'd0);
        wait_ticks(2);
        chk("press_level", {30'd0, key_state}, 32'd1);
        key_raw[0] = 1'b1;
        wait_ticks(1);
        key_raw[0] = 1'b0;
        wait_ticks(1);
        chk("glitch_back_down", {28'd0, key_fsm_state}, 32'h2);
        key_raw[0] = 1'b1;
        push_ev(t + 9, 2'b00, 2'b01, 2'b00, 2'b00);
        wait_ticks(2);
        chk("release_not_early", {30'd0, key_state}, 32'd1);
        wait_ticks(2);
        chk("release_level", {30'd0, key_state}, 32'd0);

        // Bounce: two pressed ticks only
        key_raw[0] = 1'b0;
        wait_ticks(2);
        key_raw[0] = 1'b1;
        wait_ticks(3);
        chk("bounce_state", {30'd0, key_state}, 32'd0);
        chk("bounce_fsm", {28'd0, key_fsm_state}, 32'd0);

        // Long hold on key 1
        t = tick_cnt;
        key_raw[1] = 1'b0;
        push_ev(t + 3, 2'b10, 2'b00, 2'b00, 2'b10);
`ifdef KEY_LONG_PRESS_EN
        push_ev(t + 8,  2'b00, 2'b00, 2'b10, 2'b10);
        push_ev(t + 10, 2'b00, 2'b00, 2'b10, 2'b10);
        push_ev(t + 12, 2'b00, 2'b00, 2'b10, 2'b10);
`endif
        wait_ticks(12);
        chk("long_hold_level", {30'd0, key_state}, 32'h2);
        key_raw[1] = 1'b1;
        push_ev(t + 15, 2'b00, 2'b10, 2'b00, 2'b00);
        wait_ticks(4);
        chk("long_released", {28'd0, key_state, key_long}, 32'd0);

        // Reset while key 0 is in DEB_DN and still held
        t = tick_cnt;
        key_raw[0] = 1'b0;
        wait_ticks(2);
        chk("deb_dn_before_rst", {28'd0, key_fsm_state}, 32'h1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_outputs", {24'd0, key_state, key_press, key_release, key_long}, 32'd0);
        chk("mid_rst_fsm", {28'd0, key_fsm_state}, 32'd0);
        rst = 1'b0;
        push_ev(t + 5, 2'b01, 2'b00, 2'b00, 2'b01);
        wait_ticks(2);
        chk("fresh_debounce_not_early", {30'd0, key_state}, 32'd0);
        wait_ticks(1);
        chk("fresh_debounce_level", {30'd0, key_state}, 32'd1);

        // Release key 0, then press and release both keys together
        key_raw = 2'b11;
        push_ev(t + 8, 2'b00, 2'b01, 2'b00, 2'b00);
        wait_ticks(4);
        t = tick_cnt;
        key_raw = 2'b00;
        push_ev(t + 3, 2'b11, 2'b00, 2'b00, 2'b11);
        wait_ticks(4);
        chk("both_down", {30'd0, key_state}, 32'h3);
        key_raw = 2'b11;
        push_ev(t + 7, 2'b00, 2'b11, 2'b00, 2'b00);
        wait_ticks(5);
        chk("both_up", {30'd0, key_state}, 32'd0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
